// File: rtl/mdio_phy_responder_if.sv
// MDIO pad and event bundle between a management master (or bench) and the PHY responder.
// The pad is split into input, output and tristate-enable; the board or bench resolves the wire.
interface mdio_phy_responder_if;
    logic        mdc;
    logic        mdio_i;
    logic        mdio_o;
    logic        mdio_t;
    logic        wr_valid;
    logic [4:0]  wr_reg_addr;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        frame_err;
    logic        busy;

    modport master (
        output mdc, mdio_i,
        input  mdio_o, mdio_t, wr_valid, wr_reg_addr, wr_data, rd_valid, frame_err, busy
    );

    modport slave (
        input  mdc, mdio_i,
        output mdio_o, mdio_t, wr_valid, wr_reg_addr, wr_data, rd_valid, frame_err, busy
    );
endinterface

// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY responder: oversamples MDC/MDIO on sys_clk, decodes frames addressed to
// PHY_ADDR, serves a 32 x 16 register file and reports each committed write as a pulse.
module mdio_phy_responder #(
    parameter logic [4:0]  PHY_ADDR     = 5'h03,
    parameter int          PREAMBLE_LEN = 32,
    parameter logic [15:0] PHY_ID1      = 16'h001C,
    parameter logic [15:0] PHY_ID2      = 16'hC916
) (
    input  logic                sys_clk,
    input  logic                sys_clk_rst_sync,
    mdio_phy_responder_if.slave bus
);
    localparam logic [5:0] PRE_LEN = 6'(PREAMBLE_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_ST2, S_OP, S_PHYAD, S_REGAD,
        S_TA_RD, S_RD_DATA, S_TA_WR, S_WR_DATA, S_SKIP
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  mdc_sync_q, mdio_sync_q;
    logic        mdc_prev_q;
    logic [5:0]  pre_cnt_q, pre_cnt_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] sr_q, sr_d;
    logic        is_read_q, is_read_d;
    logic [4:0]  reg_addr_q, reg_addr_d;
    logic        mdio_o_q, mdio_o_d, mdio_t_q, mdio_t_d;
    logic        wr_valid_q, wr_valid_d, rd_valid_q, rd_valid_d;
    logic        frame_err_q, frame_err_d, busy_q, busy_d;
    logic [4:0]  wr_reg_addr_q, wr_reg_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic        self_clr_q, self_clr_d;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic [15:0] regs_q [32];

    logic mdc_re, mdio_bit;
    assign mdc_re   = mdc_sync_q[1] & ~mdc_prev_q;
    assign mdio_bit = mdio_sync_q[1];

    always_ff @(posedge sys_clk or posedge sys_clk_rst_sync) begin
        if (sys_clk_rst_sync) begin
            mdc_sync_q    <= 2'b00;
            mdio_sync_q   <= 2'b11;
            mdc_prev_q    <= 1'b0;
            state_q       <= S_IDLE;
            pre_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            sr_q          <= '0;
            is_read_q     <= 1'b0;
            reg_addr_q    <= '0;
            mdio_o_q      <= 1'b1;
            mdio_t_q      <= 1'b1;
            wr_valid_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
            wr_reg_addr_q <= '0;
            wr_data_q     <= '0;
            self_clr_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
            mdc_sync_q    <= {mdc_sync_q[0], bus.mdc};
            mdio_sync_q   <= {mdio_sync_q[0], bus.mdio_i};
            mdc_prev_q    <= mdc_sync_q[1];
            state_q       <= state_d;
            pre_cnt_q     <= pre_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sr_q          <= sr_d;
            is_read_q     <= is_read_d;
            reg_addr_q    <= reg_addr_d;
            mdio_o_q      <= mdio_o_d;
            mdio_t_q      <= mdio_t_d;
            wr_valid_q    <= wr_valid_d;
            rd_valid_q    <= rd_valid_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
            wr_reg_addr_q <= wr_reg_addr_d;
            wr_data_q     <= wr_data_d;
            self_clr_q    <= self_clr_d;
        end
    end

    always_comb begin
        // NOTE: every _d defaults first so no path through this block can infer a latch.
        state_d       = state_q;
        pre_cnt_d     = pre_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sr_d          = sr_q;
        is_read_d     = is_read_q;
        reg_addr_d    = reg_addr_q;
        mdio_o_d      = mdio_o_q;
        mdio_t_d      = mdio_t_q;
        wr_valid_d    = 1'b0;
        rd_valid_d    = 1'b0;
        frame_err_d   = 1'b0;
        wr_reg_addr_d = wr_reg_addr_q;
        wr_data_d     = wr_data_q;
        self_clr_d    = 1'b0;
        reg_we        = 1'b0;
        reg_wdata     = {sr_q[14:0], mdio_bit};

        if (mdc_re) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            sr_d      = {sr_q[14:0], mdio_bit};
        end

        case (state_q)
            S_IDLE: if (mdc_re) begin
                if (mdio_bit) begin
                    pre_cnt_d = (pre_cnt_q == 6'd63) ? 6'd63 : pre_cnt_q + 6'd1;
                end else begin
                    if (pre_cnt_q >= PRE_LEN) state_d = S_ST2;
                    pre_cnt_d = '0;
                end
            end
            S_ST2: if (mdc_re) begin
                state_d   = mdio_bit ? S_OP : S_IDLE;
                bit_cnt_d = '0;
            end
            S_OP: if (mdc_re && bit_cnt_q[0]) begin
                bit_cnt_d = '0;
                case ({sr_q[0], mdio_bit})
                    2'b10:   begin is_read_d = 1'b1; state_d = S_PHYAD; end
                    2'b01:   begin is_read_d = 1'b0; state_d = S_PHYAD; end
                    default: state_d = S_IDLE;
                endcase
            end
            S_PHYAD: if (mdc_re && bit_cnt_q == 4'd4) begin
                bit_cnt_d = '0;
                state_d   = ({sr_q[3:0], mdio_bit} == PHY_ADDR) ? S_REGAD : S_SKIP;
            end
            S_REGAD: if (mdc_re && bit_cnt_q == 4'd4) begin
                bit_cnt_d  = '0;
                reg_addr_d = {sr_q[3:0], mdio_bit};
                state_d    = is_read_q ? S_TA_RD : S_TA_WR;
            end
            S_TA_RD: if (mdc_re) begin
                if (bit_cnt_q == 4'd0) begin
                    mdio_t_d = 1'b0;
                    mdio_o_d = 1'b0;
                end else begin
                    // Bit 15 goes straight to the pad; the shifter keeps the remaining bits MSB-aligned.
                    mdio_o_d   = regs_q[reg_addr_q][15];
                    sr_d       = {regs_q[reg_addr_q][14:0], 1'b0};
                    rd_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    state_d    = S_RD_DATA;
                end
            end
            S_RD_DATA: if (mdc_re) begin
                if (bit_cnt_q == 4'd15) begin
                    mdio_t_d = 1'b1;
                    mdio_o_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    mdio_o_d = sr_q[15];
                    sr_d     = {sr_q[14:0], 1'b0};
                end
            end
            S_TA_WR: if (mdc_re) begin
                if (mdio_bit != (bit_cnt_q == 4'd0)) begin
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (bit_cnt_q == 4'd1) begin
                    bit_cnt_d = '0;
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: if (mdc_re && bit_cnt_q == 4'd15) begin
                state_d = S_IDLE;
                // The PHY ID registers are read-only; writes to them are silently dropped.
                if (reg_addr_q != 5'd2 && reg_addr_q != 5'd3) begin
                    reg_we        = 1'b1;
                    wr_valid_d    = 1'b1;
                    wr_reg_addr_d = reg_addr_q;
                    wr_data_d     = reg_wdata;
                    self_clr_d    = (reg_addr_q == 5'd0) && reg_wdata[15];
                end
            end
            S_SKIP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_SKIP);
    end

    always_ff @(posedge sys_clk or posedge sys_clk_rst_sync) begin
        if (sys_clk_rst_sync) begin
            // NOTE: the register file is reset deliberately so the ID registers read correctly at once.
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 2) ? PHY_ID1 : (i == 3) ? PHY_ID2 : 16'h0000;
            end
        end else begin
            if (self_clr_q) regs_q[0][15] <= 1'b0;
            if (reg_we) regs_q[reg_addr_q] <= reg_wdata;
        end
    end

    assign bus.mdio_o      = mdio_o_q;
    assign bus.mdio_t      = mdio_t_q;
    assign bus.wr_valid    = wr_valid_q;
    assign bus.wr_reg_addr = wr_reg_addr_q;
    assign bus.wr_data     = wr_data_q;
    assign bus.rd_valid    = rd_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mdio_phy_responder.sv
// Bench for mdio_phy_responder: bit-bangs Clause 22 frames on MDC/MDIO and compares what the
// master sees on the pad and the event pulses against a frame-level register model.
module tb_mdio_phy_responder;
    localparam logic [4:0]  PHY     = 5'h03;
    localparam int          PRE_LEN = 32;
    localparam logic [15:0] ID1     = 16'h001C;
    localparam logic [15:0] ID2     = 16'hC916;
    localparam int          HALF    = 6;
    // Pad is driven from the TA-bit-1 edge to the data-bit-0 edge: 17 MDC periods.
    localparam int          READ_LOW_CYCLES = 17 * 2 * HALF;
    localparam logic [1:0]  OP_RD = 2'b10;
    localparam logic [1:0]  OP_WR = 2'b01;

    typedef struct {
        int          wr_cnt;
        logic [4:0]  wr_addr;
        logic [15:0] wr_data;
        int          err_cnt;
        int          rd_cnt;
        logic [15:0] rdata;
        logic        ta2;
        int          t_low;
        logic        busy_mid;
        logic        busy_end;
        logic        t_end;
    } obs_t;

    logic sys_clk = 1'b0;
    logic rst;
    logic m_val;
    int   tests_run = 0;
    int   tests_failed = 0;

    int          mon_wr = 0, mon_err = 0, mon_rd = 0, mon_tlow = 0;
    logic [4:0]  mon_wr_addr = '0;
    logic [15:0] mon_wr_data = '0;

    logic [15:0] model_regs [32];

    always #5 sys_clk = ~sys_clk;

    mdio_phy_responder_if bus ();
    assign bus.mdio_i = bus.mdio_t ? m_val : bus.mdio_o;

    mdio_phy_responder #(
        .PHY_ADDR     (PHY),
        .PREAMBLE_LEN (PRE_LEN),
        .PHY_ID1      (ID1),
        .PHY_ID2      (ID2)
    ) dut (
        .sys_clk          (sys_clk),
        .sys_clk_rst_sync (rst),
        .bus              (bus)
    );

    always @(negedge sys_clk) begin
        if (bus.wr_valid) begin
            mon_wr      <= mon_wr + 1;
            mon_wr_addr <= bus.wr_reg_addr;
            mon_wr_data <= bus.wr_data;
        end
        if (bus.frame_err) mon_err <= mon_err + 1;
        if (bus.rd_valid) mon_rd <= mon_rd + 1;
        if (!bus.mdio_t) mon_tlow <= mon_tlow + 1;
    end

    task automatic model_reset;
        for (int i = 0; i < 32; i++) model_regs[i] = 16'h0000;
        model_regs[2] = ID1;
        model_regs[3] = ID2;
    endtask

    // Expected observations of one frame, derived from the Clause 22 rules; updates the model.
    function automatic obs_t model_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                                         input logic [4:0] regad, input logic [1:0] ta,
                                         input logic [15:0] data);
        obs_t e;
        logic started, mine;
        e = '{default: 0};
        e.t_end    = 1'b1;
        started    = (pre >= PRE_LEN) && (op == OP_RD || op == OP_WR);
        mine       = started && (phy == PHY);
        e.busy_mid = mine;
        if (op == OP_RD) begin
            e.rdata = mine ? model_regs[regad] : 16'hFFFF;
            e.ta2   = mine ? 1'b0 : 1'b1;
            if (mine) begin
                e.rd_cnt = 1;
                e.t_low  = READ_LOW_CYCLES;
            end
        end else begin
            e.rdata = data;
            e.ta2   = ta[0];
            if (mine && ta != 2'b10) begin
                e.err_cnt = 1;
            end else if (mine && regad != 5'd2 && regad != 5'd3) begin
                e.wr_cnt  = 1;
                e.wr_addr = regad;
                e.wr_data = data;
                model_regs[regad] = (regad == 5'd0) ? (data & 16'h7FFF) : data;
            end
        end
        return e;
    endfunction

    task automatic send_bit(input logic b, output logic seen);
        m_val = b;
        repeat (HALF) @(negedge sys_clk);
        seen = bus.mdio_t ? m_val : bus.mdio_o;
        bus.mdc = 1'b1;
        repeat (HALF) @(negedge sys_clk);
        bus.mdc = 1'b0;
    endtask

    task automatic send_header(input int pre, input logic [1:0] op, input logic [4:0] phy,
                               input logic [4:0] regad);
        logic s;
        for (int i = 0; i < pre; i++) send_bit(1'b1, s);
        send_bit(1'b0, s);
        send_bit(1'b1, s);
        for (int i = 1; i >= 0; i--) send_bit(op[i], s);
        for (int i = 4; i >= 0; i--) send_bit(phy[i], s);
        for (int i = 4; i >= 0; i--) send_bit(regad[i], s);
    endtask

    task automatic run_frame(input int pre, input logic [1:0] op, input logic [4:0] phy,
                             input logic [4:0] regad, input logic [1:0] ta,
                             input logic [15:0] data, output obs_t o);
        int wr0, err0, rd0, tl0;
        logic s;
        logic [15:0] d;
        o = '{default: 0};
        d = '0;
        wr0 = mon_wr; err0 = mon_err; rd0 = mon_rd; tl0 = mon_tlow;
        send_header(pre, op, phy, regad);
        o.busy_mid = bus.busy;
        if (op == OP_RD) begin
            send_bit(1'b1, s);
            send_bit(1'b1, s);
            o.ta2 = s;
            for (int i = 0; i < 16; i++) begin
                send_bit(1'b1, s);
                d = {d[14:0], s};
            end
        end else begin
            send_bit(ta[1], s);
            send_bit(ta[0], s);
            o.ta2 = s;
            for (int i = 15; i >= 0; i--) begin
                send_bit(data[i], s);
                d = {d[14:0], s};
            end
        end
        m_val = 1'b1;
        repeat (12) @(negedge sys_clk);
        o.rdata    = d;
        o.busy_end = bus.busy;
        o.t_end    = bus.mdio_t;
        o.wr_cnt   = mon_wr - wr0;
        o.wr_addr  = mon_wr_addr;
        o.wr_data  = mon_wr_data;
        o.err_cnt  = mon_err - err0;
        o.rd_cnt   = mon_rd - rd0;
        o.t_low    = mon_tlow - tl0;
    endtask

    task automatic test_reset;
        obs_t o, e;
        rst = 1'b1;
        bus.mdc = 1'b0;
        m_val = 1'b1;
        repeat (5) @(negedge sys_clk);
        tests_run++;
        if ({bus.mdio_t, bus.mdio_o} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_pad: got t/o=%b, expected 11", {bus.mdio_t, bus.mdio_o});
        end
        tests_run++;
        if ({bus.wr_valid, bus.rd_valid, bus.frame_err, bus.busy} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got wr/rd/err/busy=%b, expected 0000",
                     {bus.wr_valid, bus.rd_valid, bus.frame_err, bus.busy});
        end
        rst = 1'b0;
        repeat (5) @(negedge sys_clk);
        model_reset();
        for (int r = 2; r <= 3; r++) begin
            e = model_frame(PRE_LEN, OP_RD, PHY, 5'(r), 2'b10, 16'h0);
            run_frame(PRE_LEN, OP_RD, PHY, 5'(r), 2'b10, 16'h0, o);
            tests_run++;
            if (o.rdata !== ((r == 2) ? ID1 : ID2)) begin
                tests_failed++;
                $display("FAIL reset_id_reg%0d: got %h, expected %h", r, o.rdata, (r == 2) ? ID1 : ID2);
            end
            tests_run++;
            if (o.ta2 !== 1'b0 || o.rd_cnt !== 1) begin
                tests_failed++;
                $display("FAIL reset_read_ta: got ta2=%b rd_valid=%0d, expected 0 and 1", o.ta2, o.rd_cnt);
            end
            tests_run++;
            if (o.t_low !== e.t_low || o.t_end !== 1'b1) begin
                tests_failed++;
                $display("FAIL reset_read_tristate: got low=%0d end_t=%b, expected %0d and 1",
                         o.t_low, o.t_end, e.t_low);
            end
        end
    endtask

    task automatic test_write_readback;
        obs_t o, e;
        logic [4:0]  addrs [2] = '{5'h1F, 5'h10};
        logic [15:0] datas [2] = '{16'h0007, 16'h7FFC};
        for (int k = 0; k < 2; k++) begin
            e = model_frame(PRE_LEN, OP_WR, PHY, addrs[k], 2'b10, datas[k]);
            run_frame(PRE_LEN, OP_WR, PHY, addrs[k], 2'b10, datas[k], o);
            tests_run++;
            if (o.wr_cnt !== 1 || o.wr_addr !== addrs[k] || o.wr_data !== datas[k]) begin
                tests_failed++;
                $display("FAIL wr_event_%0d: got cnt=%0d addr=%h data=%h, expected 1 %h %h",
                         k, o.wr_cnt, o.wr_addr, o.wr_data, addrs[k], datas[k]);
            end
            tests_run++;
            if (o.busy_mid !== 1'b1 || o.busy_end !== 1'b0) begin
                tests_failed++;
                $display("FAIL wr_busy_%0d: got mid=%b end=%b, expected 1 0", k, o.busy_mid, o.busy_end);
            end
            e = model_frame(PRE_LEN, OP_RD, PHY, addrs[k], 2'b10, 16'h0);
            run_frame(PRE_LEN, OP_RD, PHY, addrs[k], 2'b10, 16'h0, o);
            tests_run++;
            if (o.rdata !== datas[k]) begin
                tests_failed++;
                $display("FAIL readback_%0d: got %h, expected %h", k, o.rdata, datas[k]);
            end
        end
    endtask

    task automatic test_addr_filter;
        obs_t o, e;
        e = model_frame(PRE_LEN, OP_WR, 5'h05, 5'h10, 2'b10, 16'h1234);
        run_frame(PRE_LEN, OP_WR, 5'h05, 5'h10, 2'b10, 16'h1234, o);
        tests_run++;
        if (o.wr_cnt !== 0 || o.t_low !== 0 || o.busy_mid !== 1'b0) begin
            tests_failed++;
            $display("FAIL filter_write: got wr=%0d low=%0d busy=%b, expected 0 0 0",
                     o.wr_cnt, o.t_low, o.busy_mid);
        end
        e = model_frame(PRE_LEN, OP_RD, PHY, 5'h10, 2'b10, 16'h0);
        run_frame(PRE_LEN, OP_RD, PHY, 5'h10, 2'b10, 16'h0, o);
        tests_run++;
        if (o.rdata !== 16'h7FFC) begin
            tests_failed++;
            $display("FAIL filter_unchanged: got %h, expected 7ffc", o.rdata);
        end
    endtask

    task automatic test_short_preamble;
        obs_t o, e;
        e = model_frame(PRE_LEN - 1, OP_WR, PHY, 5'h05, 2'b10, 16'h1234);
        run_frame(PRE_LEN - 1, OP_WR, PHY, 5'h05, 2'b10, 16'h1234, o);
        tests_run++;
        if (o.wr_cnt !== e.wr_cnt || o.busy_mid !== 1'b0) begin
            tests_failed++;
            $display("FAIL short_pre_ignored: got wr=%0d busy=%b, expected 0 0", o.wr_cnt, o.busy_mid);
        end
        e = model_frame(PRE_LEN, OP_WR, PHY, 5'h05, 2'b10, 16'h1234);
        run_frame(PRE_LEN, OP_WR, PHY, 5'h05, 2'b10, 16'h1234, o);
        tests_run++;
        if (o.wr_cnt !== 1 || o.wr_data !== 16'h1234) begin
            tests_failed++;
            $display("FAIL full_pre_accepted: got wr=%0d data=%h, expected 1 1234", o.wr_cnt, o.wr_data);
        end
    endtask

    task automatic test_errors;
        obs_t o, e;
        e = model_frame(PRE_LEN, OP_WR, PHY, 5'h06, 2'b00, 16'h5555);
        run_frame(PRE_LEN, OP_WR, PHY, 5'h06, 2'b00, 16'h5555, o);
        tests_run++;
        if (o.err_cnt !== 1 || o.wr_cnt !== 0 || o.busy_end !== 1'b0) begin
            tests_failed++;
            $display("FAIL bad_ta: got err=%0d wr=%0d busy=%b, expected 1 0 0", o.err_cnt, o.wr_cnt, o.busy_end);
        end
        e = model_frame(PRE_LEN, OP_RD, PHY, 5'h06, 2'b10, 16'h0);
        run_frame(PRE_LEN, OP_RD, PHY, 5'h06, 2'b10, 16'h0, o);
        tests_run++;
        if (o.rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL bad_ta_no_commit: got %h, expected 0000", o.rdata);
        end
        e = model_frame(PRE_LEN, OP_WR, PHY, 5'h02, 2'b10, 16'hFFFF);
        run_frame(PRE_LEN, OP_WR, PHY, 5'h02, 2'b10, 16'hFFFF, o);
        tests_run++;
        if (o.wr_cnt !== 0 || o.err_cnt !== 0) begin
            tests_failed++;
            $display("FAIL id_write_silent: got wr=%0d err=%0d, expected 0 0", o.wr_cnt, o.err_cnt);
        end
        e = model_frame(PRE_LEN, OP_RD, PHY, 5'h02, 2'b10, 16'h0);
        run_frame(PRE_LEN, OP_RD, PHY, 5'h02, 2'b10, 16'h0, o);
        tests_run++;
        if (o.rdata !== ID1) begin
            tests_failed++;
            $display("FAIL id_write_ignored: got %h, expected %h", o.rdata, ID1);
        end
        e = model_frame(PRE_LEN, OP_WR, PHY, 5'h00, 2'b10, 16'h8000);
        run_frame(PRE_LEN, OP_WR, PHY, 5'h00, 2'b10, 16'h8000, o);
        tests_run++;
        if (o.wr_cnt !== 1 || o.wr_data !== 16'h8000) begin
            tests_failed++;
            $display("FAIL reg0_wr_event: got wr=%0d data=%h, expected 1 8000", o.wr_cnt, o.wr_data);
        end
        e = model_frame(PRE_LEN, OP_RD, PHY, 5'h00, 2'b10, 16'h0);
        run_frame(PRE_LEN, OP_RD, PHY, 5'h00, 2'b10, 16'h0, o);
        tests_run++;
        if (o.rdata !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reg0_self_clear: got %h, expected 0000", o.rdata);
        end
    endtask

    task automatic test_random;
        obs_t o, e;
        int pre;
        logic [1:0] op, ta;
        logic [4:0] phy, regad;
        logic [15:0] data;
        for (int n = 0; n < 24; n++) begin
            pre   = PRE_LEN + int'($urandom_range(0, 6));
            op    = ($urandom_range(0, 7) == 0) ? 2'($urandom) : (($urandom_range(0, 1) == 1) ? OP_RD : OP_WR);
            phy   = ($urandom_range(0, 4) == 0) ? 5'($urandom) : PHY;
            regad = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ta    = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b10;
            data  = 16'($urandom);
            e = model_frame(pre, op, phy, regad, ta, data);
            run_frame(pre, op, phy, regad, ta, data, o);
            tests_run++;
            if (o.wr_cnt !== e.wr_cnt || o.err_cnt !== e.err_cnt || o.rd_cnt !== e.rd_cnt) begin
                tests_failed++;
                $display("FAIL rand%0d_events: got wr/err/rd=%0d/%0d/%0d, expected %0d/%0d/%0d",
                         n, o.wr_cnt, o.err_cnt, o.rd_cnt, e.wr_cnt, e.err_cnt, e.rd_cnt);
            end
            if (e.wr_cnt == 1) begin
                tests_run++;
                if (o.wr_addr !== e.wr_addr || o.wr_data !== e.wr_data) begin
                    tests_failed++;
                    $display("FAIL rand%0d_wr: got %h/%h, expected %h/%h", n, o.wr_addr, o.wr_data,
                             e.wr_addr, e.wr_data);
                end
            end
            tests_run++;
            if (o.rdata !== e.rdata || o.ta2 !== e.ta2) begin
                tests_failed++;
                $display("FAIL rand%0d_pad: got data=%h ta2=%b, expected %h %b (op=%b phy=%h reg=%h)",
                         n, o.rdata, o.ta2, e.rdata, e.ta2, op, phy, regad);
            end
            tests_run++;
            if (o.t_low !== e.t_low || o.t_end !== e.t_end || o.busy_mid !== e.busy_mid || o.busy_end !== e.busy_end) begin
                tests_failed++;
                $display("FAIL rand%0d_ctrl: got low=%0d t=%b busy=%b/%b, expected %0d %b %b/%b",
                         n, o.t_low, o.t_end, o.busy_mid, o.busy_end, e.t_low, e.t_end, e.busy_mid, e.busy_end);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        obs_t o, e;
        logic s;
        logic [7:0] hi;
        e = model_frame(PRE_LEN, OP_WR, PHY, 5'h1F, 2'b10, 16'hA5A5);
        run_frame(PRE_LEN, OP_WR, PHY, 5'h1F, 2'b10, 16'hA5A5, o);
        tests_run++;
        if (o.wr_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midrst_setup: got wr=%0d, expected 1", o.wr_cnt);
        end
        hi = '0;
        send_header(PRE_LEN, OP_RD, PHY, 5'h1F);
        send_bit(1'b1, s);
        send_bit(1'b1, s);
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b1, s);
            hi = {hi[6:0], s};
        end
        tests_run++;
        if (hi !== 8'hA5) begin
            tests_failed++;
            $display("FAIL midrst_high_byte: got %h, expected a5", hi);
        end
        repeat (3) @(negedge sys_clk);
        tests_run++;
        if (bus.mdio_t !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_driving: got mdio_t=%b, expected 0", bus.mdio_t);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.mdio_t !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_release: got mdio_t=%b busy=%b, expected 1 0", bus.mdio_t, bus.busy);
        end
        repeat (4) @(negedge sys_clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge sys_clk);
        e = model_frame(PRE_LEN, OP_RD, PHY, 5'h1F, 2'b10, 16'h0);
        run_frame(PRE_LEN, OP_RD, PHY, 5'h1F, 2'b10, 16'h0, o);
        tests_run++;
        if (o.rdata !== 16'h0000 || o.rd_cnt !== 1) begin
            tests_failed++;
            $display("FAIL midrst_regfile: got %h rd=%0d, expected 0000 1", o.rdata, o.rd_cnt);
        end
        e = model_frame(PRE_LEN, OP_RD, PHY, 5'h10, 2'b10, 16'h0);
        run_frame(PRE_LEN, OP_RD, PHY, 5'h10, 2'b10, 16'h0, o);
        tests_run++;
        if (o.rdata !== e.rdata) begin
            tests_failed++;
            $display("FAIL midrst_reg10: got %h, expected %h", o.rdata, e.rdata);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_val = 1'b1;
        bus.mdc = 1'b0;
        test_reset();
        test_write_readback();
        test_addr_filter();
        test_short_preamble();
        test_errors();
        test_random();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
